// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Host-side initiator for the CPU's external memory load ports. A byte stream
// arrives over a valid/ready handshake and is decoded into command packets:
//
//   0x01 LOAD_I : addr_lo addr_hi cnt_lo cnt_hi, then cnt x 4-byte words (LE)
//   0x02 LOAD_D : addr_lo addr_hi cnt_lo cnt_hi, then cnt x 8-byte words (LE)
//   0x03 START  : raise cpu_enable
//   0x04 STOP   : drop cpu_enable
//   other       : set the sticky err flag (cleared by the next valid command)
//
// Assembled words are written to instruction memory (addr_ext/wen_ext/
// wdata_ext) or data memory (addr_ext_2/wen_ext_2/wdata_ext_2). Every
// memory-port output is a flop. The write strobe is high for exactly the
// one WR cycle that follows the edge accepting the last byte of a word.
//
// Handshake: a byte transfers on every rising clk edge where in_valid and
// in_ready are both 1. The source keeps in_data stable while in_valid=1 and
// in_ready=0, and may drop in_valid at any time; the loader simply waits,
// keeping all partial header/word state, with no timeout. in_ready is
// registered: it is 1 in IDLE, HDR and PAY and 0 in WR (and 0 while reset is
// asserted, since every output is 0 in reset).
//
// Ports:
//   clk          in   main clock
//   arst_n       in   asynchronous active-low reset
//   in_valid     in   input byte valid
//   in_data      in   input byte [7:0]
//   in_ready     out  loader accepts a byte this cycle
//   addr_ext     out  instruction memory byte address (zero-extended) [63:0]
//   wen_ext      out  instruction memory write enable
//   ren_ext      out  instruction memory read enable, tied 0
//   wdata_ext    out  instruction memory write word [31:0]
//   addr_ext_2   out  data memory byte address (zero-extended) [63:0]
//   wen_ext_2    out  data memory write enable
//   ren_ext_2    out  data memory read enable, tied 0
//   wdata_ext_2  out  data memory write word [63:0]
//   cpu_enable   out  CPU enable
//   busy         out  1 whenever the FSM is not in IDLE
//   err          out  sticky unknown-command flag
//   fsm_state    out  current FSM state (0 IDLE, 1 HDR, 2 PAY, 3 WR), debug
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  localparam logic [7:0] CMD_LOAD_I = 8'h01;
  localparam logic [7:0] CMD_LOAD_D = 8'h02;
  localparam logic [7:0] CMD_START  = 8'h03;
  localparam logic [7:0] CMD_STOP   = 8'h04;

  state_t state;
  state_t state_next;

  logic              accept;     // byte transferred at the coming edge
  logic              is_load;    // in_data is a load command
  logic              is_d;       // current load targets data memory
  logic [1:0]        hdr_idx;    // header byte position 0..3
  logic [7:0]        hdr_lo;     // low byte of the addr/cnt field in flight
  logic [2:0]        byte_idx;   // payload byte position within a word
  logic              last_byte;  // in_data is the final byte of the word
  logic              last_word;  // the word in WR is the final one
  logic [ADDR_W-1:0] addr_q;     // address of the word being assembled
  logic [ADDR_W-1:0] addr_step;
  logic [CNT_W-1:0]  cnt_q;      // words remaining, including the current one
  logic [CNT_W-1:0]  cnt_hdr;    // count as it completes in the header
  logic [63:0]       word_q;     // bytes gathered so far
  logic [63:0]       word_next;  // word_q with the incoming byte merged in

  assign accept    = in_valid & in_ready;
  assign is_load   = (in_data == CMD_LOAD_I) || (in_data == CMD_LOAD_D);
  assign last_byte = is_d ? (byte_idx == 3'd7) : (byte_idx == 3'd3);
  assign last_word = (cnt_q == CNT_W'(1));
  assign addr_step = is_d ? ADDR_W'(8) : ADDR_W'(4);
  // The count is only meaningful at the 4th header byte, where hdr_lo holds
  // cnt_lo and in_data carries cnt_hi.
  assign cnt_hdr   = CNT_W'({in_data, hdr_lo});

  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // Little-endian lane merge: byte k lands in bits [8k+7:8k].
  always_comb begin
    word_next = word_q;
    word_next[{byte_idx, 3'b000} +: 8] = in_data;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && is_load) begin
          state_next = S_HDR;
        end
      end
      S_HDR: begin
        // A zero-count load finishes right after its header, without a write.
        if (accept && (hdr_idx == 2'd3)) begin
          state_next = (cnt_hdr != '0) ? S_PAY : S_IDLE;
        end
      end
      S_PAY: begin
        if (accept && last_byte) begin
          state_next = S_WR;
        end
      end
      S_WR: begin
        state_next = last_word ? S_IDLE : S_PAY;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      in_ready    <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      cpu_enable  <= 1'b0;
      err         <= 1'b0;
      is_d        <= 1'b0;
      hdr_idx     <= '0;
      hdr_lo      <= '0;
      byte_idx    <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
    end else begin
      // in_ready follows the state we are entering, so it is low exactly in WR.
      in_ready  <= (state_next != S_WR);
      // Strobes are single-cycle; they are only raised on entry to WR.
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            case (in_data)
              CMD_LOAD_I, CMD_LOAD_D: begin
                // Never write memory while the CPU runs.
                is_d       <= (in_data == CMD_LOAD_D);
                hdr_idx    <= '0;
                cpu_enable <= 1'b0;
                err        <= 1'b0;
              end
              CMD_START: begin
                cpu_enable <= 1'b1;
                err        <= 1'b0;
              end
              CMD_STOP: begin
                cpu_enable <= 1'b0;
                err        <= 1'b0;
              end
              default: begin
                err <= 1'b1;
              end
            endcase
          end
        end

        S_HDR: begin
          if (accept) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0, 2'd2: hdr_lo <= in_data;
              2'd1:       addr_q <= ADDR_W'({in_data, hdr_lo});
              default: begin
                cnt_q    <= cnt_hdr;
                byte_idx <= '0;
              end
            endcase
          end
        end

        S_PAY: begin
          if (accept) begin
            word_q <= word_next;
            if (last_byte) begin
              byte_idx <= '0;
              if (is_d) begin
                wen_ext_2   <= 1'b1;
                addr_ext_2  <= 64'(addr_q);
                wdata_ext_2 <= word_next;
              end else begin
                wen_ext     <= 1'b1;
                addr_ext    <= 64'(addr_q);
                wdata_ext   <= word_next[31:0];
              end
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end

        S_WR: begin
          // Address wraps modulo 2^ADDR_W by plain overflow.
          addr_q <= addr_q + addr_step;
          cnt_q  <= cnt_q - CNT_W'(1);
        end

        default: begin
        end
      endcase
    end
  end

endmodule
